alu_mul_seq: RTL and testbench
==============================

Name: alu_mul_seq

Overview:
- Multi-cycle 16x16->32 shift-add multiplier sequencer that borrows the shared 16-bit ALU instead of instantiating its own adder.
- Sits beside the execute stage. While busy it owns the ALU control and operand inputs (alu_own=1 selects its drive over the decoder's), stalls the pipeline, and returns a 32-bit product.
- Uses the ALU encodings already in the design: ADD Op=5'b00100; subtract = invA=1, Cin=1 (B-A).

Parameters:
- WIDTH, 16, operand width; product is 2*WIDTH. Only 16 is verified.
- CNT_W, 4, iteration counter width (log2 WIDTH).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  request; accepted only when ready=1
- mul_signed  in  1  operands are two's complement (effective only with MUL_SIGNED_EN)
- mcand  in  16  multiplicand, sampled on accepted start
- mplier  in  16  multiplier, sampled on accepted start
- ready  out  1  idle, can accept start
- busy  out  1  operation in progress; pipeline stall request
- done  out  1  one-cycle pulse, product valid
- product  out  32  result, held until next accepted start
- alu_own  out  1  sequencer drives ALU this cycle
- alu_a  out  16  ALU operand A
- alu_b  out  16  ALU operand B
- alu_op  out  5  ALU Op code
- alu_cin, alu_inva, alu_invb, alu_sign  out  1 each  ALU controls
- alu_out  in  16  combinational ALU result, same cycle
- alu_cout  in  1  ALU carry out

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, ready=1, busy=0, done=0, product=0, alu_own=0, counter=0, internal registers=0.
- Registers: mc_r (16), acc_hi (16), acc_lo (16, holds the multiplier initially), cnt (CNT_W), sgn_r, mc_neg, mp_neg.
- IDLE:
  - ready=1.
  - On start: mc_r<=mcand, acc_lo<=mplier, acc_hi<=0, cnt<=0, capture sign flags (mc_neg=mcand[15], mp_neg=mplier[15], sgn_r=mul_signed).
  - Go to RUN.
- RUN (16 cycles):
  - alu_own=1, alu_a=mc_r, alu_b=acc_hi, alu_op=00100, alu_cin=0, alu_inva=0, alu_invb=0, alu_sign=0.
  - sum33 = acc_lo[0] ? {alu_cout, alu_out} : {1'b0, acc_hi}.
  - {acc_hi, acc_lo} <= {sum33, acc_lo[15:1]} (33-bit right shift, carry enters bit 31).
  - cnt++. At cnt==15 go to CORR_A if signed correction applies, else DONE.
- CORR_A (signed only; skipped unless sgn_r && mp_neg):
  - alu_a=mc_r, alu_b=acc_hi, alu_inva=1, alu_cin=1, alu_op=00100.
  - acc_hi<=alu_out (subtracts mcand<<16).
  - Next state CORR_B.
- CORR_B (signed only; skipped unless sgn_r && mc_neg):
  - alu_a=acc_lo_orig_mplier, alu_b=acc_hi, same controls as CORR_A; acc_hi<=alu_out.
  - Original mplier is kept in register mp_r.
  - Next state DONE.
- DONE:
  - done=1 for exactly one cycle, product<={acc_hi, acc_lo}, alu_own=0.
  - Go to IDLE. start in this cycle is ignored (ready=0).
- busy=1 in RUN, CORR_A, CORR_B and DONE. ready = (state==IDLE).
- Latency: start accepted at edge 0, done high in cycle 17 (unsigned). Signed with corrections: up to cycle 19.
- When alu_own=0, ALU outputs are held at 0 with alu_op=00100 (ADD).
- start while busy: ignored; no queueing.
- rst mid-operation: immediate return to reset values; no done pulse.
- Zero operands: normal 16-cycle run, product=0.
- Carry is lost only in the correction cycles; this is intended (modulo 2^32 arithmetic).

Optional Feature:
- Macro: MUL_SIGNED_EN.
- Defined: CORR_A/CORR_B exist; mul_signed=1 yields the two's-complement signed product.
- Undefined: the correction states and mp_r are not built. mul_signed is still a port but ignored; all products are unsigned and latency is always 17.

Decomposition:
- Shared package wisc_alu_pkg:
  - ALU Op constants ALU_OP_ADD=5'b00100, ALU_OP_SLL=5'b00001, ALU_OP_SRL=5'b00011.
  - Sequencer state encoding (IDLE, RUN, CORR_A, CORR_B, DONE; 3 bits).
  - WIDTH default.
- One sub-module is natural: mul_acc_shreg. It holds the 33-bit right-shifting acc_hi/acc_lo pair with load/shift/update-hi controls. The FSM and ALU drive stay in alu_mul_seq.

Test Plan:
- mcand=3, mplier=5, unsigned -> done in cycle 17, product=0x0000000F; alu_op=00100 and alu_own=1 in all RUN cycles.
- mcand=0xFFFF, mplier=0xFFFF, unsigned -> product=0xFFFE0001, which exercises the carry into bit 31.
- MUL_SIGNED_EN: mcand=0xFFFF, mplier=0xFFFF, signed -> product=0x00000001, done in cycle 19. mcand=0x8000, mplier=0x0002, signed -> product=0xFFFF0000, done in cycle 18.
- start pulsed during cycles 3 and 17 of an active op -> ignored; product and done unchanged; ready stays 0 until IDLE.
- rst asserted in RUN cycle 8 -> next cycle busy=0, ready=1, product=0, no done pulse. A new 2*7 op afterwards gives 0x0000000E.
- Without MUL_SIGNED_EN, mul_signed=1, mcand=0xFFFF, mplier=0x0002 -> product=0x0001FFFE, latency 17.

Source files
------------

// File: rtl/wisc_alu_pkg.sv
// Shared definitions for the WISC ALU and the shift-add multiply sequencer.
// Optional signed multiply is enabled by defining MUL_SIGNED_EN.
package wisc_alu_pkg;

  localparam int unsigned MUL_WIDTH = 16;
  localparam int unsigned MUL_CNT_W = 4;
  localparam int unsigned ALU_OP_W  = 5;

  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 5'b00100;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLL = 5'b00001;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SRL = 5'b00011;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_CORR_A = 3'd2,
    ST_CORR_B = 3'd3,
    ST_DONE   = 3'd4
  } mul_state_e;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Request/result handshake plus the borrowed-ALU drive of the multiply sequencer.
interface alu_mul_seq_if
  import wisc_alu_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
);
  logic                  start;
  logic                  mul_signed;
  logic [WIDTH-1:0]      mcand;
  logic [WIDTH-1:0]      mplier;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic [2*WIDTH-1:0]    product;
  logic                  alu_own;
  logic [WIDTH-1:0]      alu_a;
  logic [WIDTH-1:0]      alu_b;
  logic [ALU_OP_W-1:0]   alu_op;
  logic                  alu_cin;
  logic                  alu_inva;
  logic                  alu_invb;
  logic                  alu_sign;
  logic [WIDTH-1:0]      alu_out;
  logic                  alu_cout;

  // Requester side, which also hosts the shared ALU
  modport master (
    output start, mul_signed, mcand, mplier, alu_out, alu_cout,
    input  ready, busy, done, product,
    input  alu_own, alu_a, alu_b, alu_op, alu_cin, alu_inva, alu_invb, alu_sign
  );

  // Sequencer side
  modport slave (
    input  start, mul_signed, mcand, mplier, alu_out, alu_cout,
    output ready, busy, done, product,
    output alu_own, alu_a, alu_b, alu_op, alu_cin, alu_inva, alu_invb, alu_sign
  );
endinterface

// File: rtl/mul_acc_shreg.sv
// 33-bit right-shifting accumulator pair {acc_hi, acc_lo} for shift-add multiply.
module mul_acc_shreg #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift,
  input  logic               upd_hi,
  input  logic [WIDTH-1:0]   lo_in,
  input  logic [WIDTH-1:0]   hi_in,
  input  logic [WIDTH:0]     sum_in,
  output logic [2*WIDTH-1:0] acc_nxt_c
);
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH:0]   sum33_c;

  // Add the multiplicand only when the current multiplier bit is set
  always_comb sum33_c = acc_lo[0] ? sum_in : {1'b0, acc_hi};

  // Next accumulator value; exposed so the owner can register derived outputs
  always_comb begin
    acc_nxt_c = {acc_hi, acc_lo};
    if (load)
      acc_nxt_c = {{WIDTH{1'b0}}, lo_in};
    else if (shift)
      acc_nxt_c = {sum33_c, acc_lo[WIDTH-1:1]};
    else if (upd_hi)
      acc_nxt_c = {hi_in, acc_lo};
  end

  // Accumulator register
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_hi <= '0;
      acc_lo <= '0;
    end else begin
      {acc_hi, acc_lo} <= acc_nxt_c;
    end
  end
endmodule

// File: rtl/alu_mul_seq.sv
// 16x16->32 shift-add multiplier that borrows the shared ALU adder.
// Define MUL_SIGNED_EN to build the two's-complement correction states.
module alu_mul_seq
  import wisc_alu_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH,
  parameter int unsigned CNT_W = MUL_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  alu_mul_seq_if.slave bus
);
  mul_state_e         state, nxt;
  logic [WIDTH-1:0]   mc_r;
  logic [CNT_W-1:0]   cnt;
  logic               acc_load, acc_shift, acc_upd;
  logic [2*WIDTH-1:0] acc_nxt_c;
  logic [WIDTH-1:0]   mc_nxt, hi_nxt;
  mul_state_e         run_exit;

  logic               ready_r, busy_r, done_r;
  logic [2*WIDTH-1:0] product_r;
  logic               own_r, cin_r, inva_r;
  logic [WIDTH-1:0]   a_r, b_r;
  logic               own_d, cin_d, inva_d;
  logic [WIDTH-1:0]   a_d, b_d;

`ifdef MUL_SIGNED_EN
  logic [WIDTH-1:0]   mp_r;
  logic               sgn_r, mc_neg, mp_neg;
  logic               corr_a_en, corr_b_en;

  assign corr_a_en = sgn_r & mp_neg;
  assign corr_b_en = sgn_r & mc_neg;
  assign run_exit  = corr_a_en ? ST_CORR_A : (corr_b_en ? ST_CORR_B : ST_DONE);

  // Sign information and original multiplier for the final corrections
  always_ff @(posedge clk) begin
    if (rst) begin
      mp_r   <= '0;
      sgn_r  <= 1'b0;
      mc_neg <= 1'b0;
      mp_neg <= 1'b0;
    end else if (acc_load) begin
      mp_r   <= bus.mplier;
      sgn_r  <= bus.mul_signed;
      mc_neg <= bus.mcand[WIDTH-1];
      mp_neg <= bus.mplier[WIDTH-1];
    end
  end
`else
  logic unused_mul_signed;
  assign unused_mul_signed = bus.mul_signed;
  assign run_exit          = ST_DONE;
`endif

  mul_acc_shreg #(.WIDTH(WIDTH)) u_acc (
    .clk       (clk),
    .rst       (rst),
    .load      (acc_load),
    .shift     (acc_shift),
    .upd_hi    (acc_upd),
    .lo_in     (bus.mplier),
    .hi_in     (bus.alu_out),
    .sum_in    ({bus.alu_cout, bus.alu_out}),
    .acc_nxt_c (acc_nxt_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt;
  end

  // Next state and accumulator controls
  always_comb begin
    nxt       = state;
    acc_load  = 1'b0;
    acc_shift = 1'b0;
    acc_upd   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          acc_load = 1'b1;
          nxt      = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_shift = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) nxt = run_exit;
      end
`ifdef MUL_SIGNED_EN
      ST_CORR_A: begin
        acc_upd = 1'b1;
        nxt     = corr_b_en ? ST_CORR_B : ST_DONE;
      end
      ST_CORR_B: begin
        acc_upd = 1'b1;
        nxt     = ST_DONE;
      end
`endif
      ST_DONE: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  // Multiplicand and iteration counter
  always_ff @(posedge clk) begin
    if (rst) begin
      mc_r <= '0;
      cnt  <= '0;
    end else if (acc_load) begin
      mc_r <= bus.mcand;
      cnt  <= '0;
    end else if (acc_shift) begin
      cnt  <= cnt + CNT_W'(1);
    end
  end

  // ALU drive for the upcoming cycle, built from next-cycle register values
  always_comb begin
    mc_nxt = acc_load ? bus.mcand : mc_r;
    hi_nxt = acc_nxt_c[2*WIDTH-1:WIDTH];
    own_d  = 1'b0;
    a_d    = '0;
    b_d    = '0;
    cin_d  = 1'b0;
    inva_d = 1'b0;
    case (nxt)
      ST_RUN: begin
        own_d = 1'b1;
        a_d   = mc_nxt;
        b_d   = hi_nxt;
      end
`ifdef MUL_SIGNED_EN
      ST_CORR_A: begin
        own_d  = 1'b1;
        a_d    = mc_nxt;
        b_d    = hi_nxt;
        cin_d  = 1'b1;
        inva_d = 1'b1;
      end
      ST_CORR_B: begin
        own_d  = 1'b1;
        a_d    = mp_r;
        b_d    = hi_nxt;
        cin_d  = 1'b1;
        inva_d = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Registered status, product and ALU drive
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_r   <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= '0;
      own_r     <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      cin_r     <= 1'b0;
      inva_r    <= 1'b0;
    end else begin
      ready_r <= (nxt == ST_IDLE);
      busy_r  <= (nxt != ST_IDLE);
      done_r  <= (nxt == ST_DONE);
      if (nxt == ST_DONE) product_r <= acc_nxt_c;
      own_r   <= own_d;
      a_r     <= a_d;
      b_r     <= b_d;
      cin_r   <= cin_d;
      inva_r  <= inva_d;
    end
  end

  assign bus.ready    = ready_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.product  = product_r;
  assign bus.alu_own  = own_r;
  assign bus.alu_a    = a_r;
  assign bus.alu_b    = b_r;
  assign bus.alu_op   = ALU_OP_ADD;
  assign bus.alu_cin  = cin_r;
  assign bus.alu_inva = inva_r;
  assign bus.alu_invb = 1'b0;
  assign bus.alu_sign = 1'b0;
endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq with a behavioural shared ALU.
// Signed vectors are run when MUL_SIGNED_EN is defined.
module tb_alu_mul_seq;
  import wisc_alu_pkg::*;

  typedef struct {
    logic [31:0] prod;
    int          lat;
    int          t0;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];

  alu_mul_seq_if #(.WIDTH(16)) bus ();

  alu_mul_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared ALU: add with optional operand inversion and carry-in
  assign {bus.alu_cout, bus.alu_out} = 17'(bus.alu_inva ? ~bus.alu_a : bus.alu_a)
                                     + 17'(bus.alu_invb ? ~bus.alu_b : bus.alu_b)
                                     + 17'(bus.alu_cin);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Wait for ready, present one request, and record the expected result
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s,
                       input logic [31:0] p, input int lat);
    int n;
    n = 0;
    while (!bus.ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("issue_ready", 64'(bus.ready), 64'(1));
    bus.start      = 1'b1;
    bus.mcand      = a;
    bus.mplier     = b;
    bus.mul_signed = s;
    sb.push_back('{p, lat, cyc + 1});
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !bus.ready) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", 64'(n < 60), 64'(1));
  endtask

  // Monitor: every done pulse is matched against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 64'(bus.done), 64'(0));
        end else begin
          e = sb.pop_front();
          chk("product", 64'(bus.product), 64'(e.prod));
          chk("latency", 64'(cyc - e.t0 + 1), 64'(e.lat));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.start      = 1'b0;
    bus.mul_signed = 1'b0;
    bus.mcand      = '0;
    bus.mplier     = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready",   64'(bus.ready),   64'(1));
    chk("rst_busy",    64'(bus.busy),    64'(0));
    chk("rst_done",    64'(bus.done),    64'(0));
    chk("rst_product", 64'(bus.product), 64'(0));
    chk("rst_own",     64'(bus.alu_own), 64'(0));
    chk("rst_op",      64'(bus.alu_op),  64'(5'b00100));
    rst = 1'b0;
    @(negedge clk);

    // 3*5 with per-cycle check of the ALU ownership and op
    issue(16'd3, 16'd5, 1'b0, 32'h0000_000F, 17);
    chk("run_a_first", 64'(bus.alu_a), 64'(3));
    for (int k = 0; k < 16; k++) begin
      chk("run_own_op", 64'({bus.alu_own, bus.alu_op, bus.busy}), 64'({1'b1, 5'b00100, 1'b1}));
      @(negedge clk);
    end
    drain();

    issue(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 17);
    drain();
    issue(16'h0000, 16'h0000, 1'b0, 32'h0000_0000, 17);
    drain();
    issue(16'h1234, 16'h0100, 1'b0, 32'h0012_3400, 17);
    drain();

    // start pulses in cycles 3 and 17 of an active op are ignored
    issue(16'd4, 16'd6, 1'b0, 32'h0000_0018, 17);
    repeat (2) @(negedge clk);
    bus.start  = 1'b1;
    bus.mcand  = 16'd9;
    bus.mplier = 16'd9;
    @(negedge clk);
    bus.start = 1'b0;
    chk("ign_ready_c4", 64'(bus.ready), 64'(0));
    repeat (13) @(negedge clk);
    chk("ign_ready_c17", 64'(bus.ready), 64'(0));
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("ign_ready_c18", 64'(bus.ready), 64'(1));
    chk("ign_busy_c18",  64'(bus.busy),  64'(0));
    chk("ign_prod_c18",  64'(bus.product), 64'(32'h0000_0018));
    repeat (3) @(negedge clk);
    chk("ign_busy_later", 64'(bus.busy), 64'(0));
    drain();

    // reset during RUN cycle 8 aborts with no done pulse
    issue(16'h1234, 16'h0010, 1'b0, 32'h0001_2340, 17);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    sb.delete();
    chk("mrst_busy",    64'(bus.busy),    64'(0));
    chk("mrst_ready",   64'(bus.ready),   64'(1));
    chk("mrst_product", 64'(bus.product), 64'(0));
    chk("mrst_own",     64'(bus.alu_own), 64'(0));
    rst = 1'b0;
    repeat (20) @(negedge clk);
    issue(16'd2, 16'd7, 1'b0, 32'h0000_000E, 17);
    drain();

`ifdef MUL_SIGNED_EN
    issue(16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001, 19);
    drain();
    issue(16'h8000, 16'h0002, 1'b1, 32'hFFFF_0000, 18);
    drain();
    issue(16'h0003, 16'hFFFB, 1'b1, 32'hFFFF_FFF1, 18);
    drain();
    issue(16'd3, 16'd5, 1'b1, 32'h0000_000F, 17);
    drain();
`else
    issue(16'hFFFF, 16'h0002, 1'b1, 32'h0001_FFFE, 17);
    drain();
    issue(16'h8000, 16'h0002, 1'b1, 32'h0001_0000, 17);
    drain();
`endif

    repeat (5) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
